crossbar_route_ctl: RTL

- Upstream neighbour of the 4x4 crossbar switch. Produces the four 2-bit selectors, one per input, that pick the destination channel buffer for each input.
- Accepts route writes from the mode-control stage into a shadow map and checks that the map is a permutation (no two inputs to the same output).
- Applies the checked map atomically on the frame boundary, so the LED channels never see a torn or conflicting route mid-frame.

---
 rtl/crossbar_route_ctl_pkg.sv | 25 ++
 rtl/crossbar_route_ctl_perm_check.sv | 38 +++
 rtl/crossbar_route_ctl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/crossbar_route_ctl_pkg.sv
// Shared crossbar types: selector width, port count, route-control states
// and the identity route map. Also imported by the 4x4 crossbar switch.
package strichlux_xbar_pkg;

  localparam int XBAR_PORTS = 4;

  typedef logic [1:0] xbar_sel_t;
  typedef xbar_sel_t [XBAR_PORTS-1:0] xbar_map_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WAIT_SYNC = 2'd2,
    APPLY     = 2'd3
  } xbar_state_t;

  localparam xbar_sel_t XBAR_SEL_A = 2'd0;
  localparam xbar_sel_t XBAR_SEL_B = 2'd1;
  localparam xbar_sel_t XBAR_SEL_C = 2'd2;
  localparam xbar_sel_t XBAR_SEL_D = 2'd3;

  // Element 0 is input a.
  localparam xbar_map_t XBAR_IDENTITY_MAP = {XBAR_SEL_D, XBAR_SEL_C, XBAR_SEL_B, XBAR_SEL_A};

endpackage

// File: rtl/crossbar_route_ctl_perm_check.sv
// Sequential duplicate-destination checker: walks the route map one input per
// cycle, marking used outputs; dup reports any output claimed twice.
module xbar_perm_check
  import strichlux_xbar_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  input  logic      en,
  input  xbar_map_t map,
  output logic      done,
  output logic      dup
);

  logic [1:0]            idx_p0;
  logic [XBAR_PORTS-1:0] used_p0;
  logic                  dup_p0;
  logic                  dup_now;

  // The current index is folded in combinationally so the verdict is ready
  // in the same cycle the last input is examined.
  assign dup_now = used_p0[map[idx_p0]];
  assign done    = en && (idx_p0 == 2'd3);
  assign dup     = dup_p0 | dup_now;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      idx_p0  <= '0;
      used_p0 <= '0;
      dup_p0  <= 1'b0;
    end else if (en) begin
      idx_p0            <= idx_p0 + 2'd1;
      used_p0[map[idx_p0]] <= 1'b1;
      dup_p0            <= dup_p0 | dup_now;
    end
  end

endmodule

// File: rtl/crossbar_route_ctl.sv
// Crossbar route controller: shadow route map, permutation check, and atomic
// frame-synchronous apply. Define XBAR_ROUTE_IMMEDIATE_EN to apply right after the check.
module crossbar_route_ctl
  import strichlux_xbar_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT = 16'hFFFF,
  parameter int unsigned TIMEOUT_W    = 16
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      cmd_valid_in,
  output logic      cmd_ready_out,
  input  logic [1:0] cmd_input_in,
  input  logic [1:0] cmd_output_in,
  input  logic      commit_in,
  input  logic      frame_sync_in,
  output xbar_sel_t xbar_selectors_a,
  output xbar_sel_t xbar_selectors_b,
  output xbar_sel_t xbar_selectors_c,
  output xbar_sel_t xbar_selectors_d,
  output logic      busy_out,
  output logic      error_out,
  output logic      timeout_out
);

  xbar_state_t state_p0;
  xbar_state_t state_nxt;
  xbar_map_t   shadow_map_p0;
  xbar_map_t   active_map_p1;

  logic cmd_fire;
  logic chk_start;
  logic chk_en;
  logic chk_done;
  logic chk_dup;
  logic chk_reject;

  assign cmd_fire   = cmd_valid_in && (state_p0 == IDLE);
  assign chk_start  = commit_in && (state_p0 == IDLE);
  assign chk_en     = (state_p0 == CHECK);
  assign chk_reject = chk_done && chk_dup;

  xbar_perm_check u_perm_check (
    .clk   (clk_in),
    .rst   (rst_in),
    .start (chk_start),
    .en    (chk_en),
    .map   (shadow_map_p0),
    .done  (chk_done),
    .dup   (chk_dup)
  );

`ifndef XBAR_ROUTE_IMMEDIATE_EN
  logic [TIMEOUT_W-1:0] wait_cnt_p0;
  logic                 timeout_hit;

  assign timeout_hit = (wait_cnt_p0 == TIMEOUT_W'(SYNC_TIMEOUT - 1));

  // Counter runs only in WAIT_SYNC, so it is zero on every entry.
  always_ff @(posedge clk_in) begin
    if (rst_in || (state_p0 != WAIT_SYNC)) wait_cnt_p0 <= '0;
    else                                   wait_cnt_p0 <= wait_cnt_p0 + 1'b1;
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) state_p0 <= IDLE;
    else        state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE: if (commit_in) state_nxt = CHECK;
      CHECK: begin
        if (chk_done) begin
          if (chk_dup) state_nxt = IDLE;
          else begin
`ifdef XBAR_ROUTE_IMMEDIATE_EN
            state_nxt = APPLY;
`else
            state_nxt = WAIT_SYNC;
`endif
          end
        end
      end
`ifndef XBAR_ROUTE_IMMEDIATE_EN
      WAIT_SYNC: if (frame_sync_in || timeout_hit) state_nxt = APPLY;
`endif
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_out = (state_p0 == IDLE);
    busy_out      = (state_p0 != IDLE);
    error_out     = chk_reject;
`ifdef XBAR_ROUTE_IMMEDIATE_EN
    timeout_out   = 1'b0;
`else
    timeout_out   = (state_p0 == WAIT_SYNC) && !frame_sync_in && timeout_hit;
`endif
  end

  // Shadow/active maps: writes only in IDLE, rejection restores the shadow,
  // and APPLY swaps the whole map in one edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shadow_map_p0 <= XBAR_IDENTITY_MAP;
      active_map_p1 <= XBAR_IDENTITY_MAP;
    end else begin
      if (cmd_fire)   shadow_map_p0[cmd_input_in] <= cmd_output_in;
      if (chk_reject) shadow_map_p0 <= active_map_p1;
      if (state_p0 == APPLY) active_map_p1 <= shadow_map_p0;
    end
  end

  assign xbar_selectors_a = active_map_p1[0];
  assign xbar_selectors_b = active_map_p1[1];
  assign xbar_selectors_c = active_map_p1[2];
  assign xbar_selectors_d = active_map_p1[3];

endmodule
